// File: rtl/s_stream_packer.sv
// Packs a stream of 2-bit nucleotides into 128-bit words. Words are buffered
// two deep and handed to Top one per request, with a valid count and a done pulse.
module s_stream_packer #(
    parameter int PE_NUM = 64,
    parameter int CHAR_W = 2,
    parameter int CNT_W  = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic [CHAR_W-1:0]        i_char,
    input  logic                     i_char_valid,
    input  logic                     i_char_last,
    output logic                     o_char_ready,
    input  logic                     i_request_s,
    output logic [PE_NUM*CHAR_W-1:0] o_s,
    output logic [CNT_W-1:0]         o_s_valid,
    output logic                     o_seq_done
);
    localparam int DATA_W = PE_NUM * CHAR_W;
    localparam int POS_W  = $clog2(PE_NUM);
    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  count;
    } entry_t;

    logic [POS_W-1:0]  pos;
    logic [DATA_W-1:0] asm_q;
    entry_t            mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;

    logic              accept;
    logic              close;
    logic              push;
    logic              pop;
    entry_t            new_entry;

    assign o_char_ready = (fifo_count != 2'd2);
    assign accept       = i_char_valid && o_char_ready && !i_flush;
    assign close        = accept && (i_char_last || pos == POS_W'(PE_NUM - 1));
    assign push         = close;
    // Deliveries are spaced by the registered o_s_valid, so Top sees each word once.
    assign pop          = i_request_s && (fifo_count != 2'd0) && (o_s_valid == '0) && !i_flush;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        new_entry.data  = asm_q | (DATA_W'(i_char) << (CHAR_W * pos));
        new_entry.count = CNT_FULL;
        if (i_char_last) begin
            new_entry.count = CNT_W'(pos) + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos        <= '0;
            asm_q      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            o_s        <= '0;
            o_s_valid  <= '0;
            o_seq_done <= 1'b0;
        end else if (i_flush) begin
            pos        <= '0;
            asm_q      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            o_s        <= '0;
            o_s_valid  <= '0;
            o_seq_done <= 1'b0;
        end else begin
            if (accept) begin
                if (close) begin
                    pos   <= '0;
                    asm_q <= '0;
                end else begin
                    pos   <= pos + POS_W'(1);
                    asm_q <= new_entry.data;
                end
            end

            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 2'd1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 2'd1;
            end

            if (pop) begin
                o_s        <= mem[rd_ptr].data;
                o_s_valid  <= mem[rd_ptr].count;
                o_seq_done <= (mem[rd_ptr].count != CNT_FULL);
            end else begin
                o_s        <= '0;
                o_s_valid  <= '0;
                o_seq_done <= 1'b0;
            end
        end
    end

    // NOTE: buffer storage is not reset; pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

endmodule

// File: tb/tb_s_stream_packer.sv
// Scoreboard bench for s_stream_packer: directed sequences push hand-computed
// words into a queue, and an independent monitor checks each delivery.
module tb_s_stream_packer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_flush = 1'b0;
    logic [1:0]   i_char = 2'd0;
    logic         i_char_valid = 1'b0;
    logic         i_char_last = 1'b0;
    logic         o_char_ready;
    logic         i_request_s = 1'b0;
    logic [127:0] o_s;
    logic [6:0]   o_s_valid;
    logic         o_seq_done;

    typedef struct packed {
        logic [127:0] data;
        logic [6:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   deliveries = 0;
    int   done_pulses = 0;
    int   n_acc = 0;
    logic prev_valid = 1'b0;

    localparam logic [127:0] PAT_E4 = {16{8'hE4}};

    s_stream_packer #(.PE_NUM(64), .CHAR_W(2), .CNT_W(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (i_flush),
        .i_char       (i_char),
        .i_char_valid (i_char_valid),
        .i_char_last  (i_char_last),
        .o_char_ready (o_char_ready),
        .i_request_s  (i_request_s),
        .o_s          (o_s),
        .o_s_valid    (o_s_valid),
        .o_seq_done   (o_seq_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] data, input logic [6:0] cnt);
        exp_t e;
        e.data = data;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the character is taken.
    task automatic send_char(input logic [1:0] c, input logic last);
        int t = 0;
        i_char       = c;
        i_char_valid = 1'b1;
        i_char_last  = last;
        while (!o_char_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("ready_timeout", o_char_ready, 1);
        @(posedge clk);
        n_acc++;
        @(negedge clk);
        i_char_valid = 1'b0;
        i_char_last  = 1'b0;
    endtask

    task automatic send_seq(input int n, input logic with_last);
        for (int k = 0; k < n; k++) begin
            send_char(2'(k % 4), with_last && (k == n - 1));
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (o_s_valid != 7'd0) begin
                    deliveries++;
                    check("spacing", prev_valid, 0);
                    if (sb.size() == 0) begin
                        check("unexpected_word", o_s_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("word_data", o_s, e.data);
                        check("word_count", o_s_valid, e.cnt);
                        check("seq_done", o_seq_done, e.cnt != 7'h7F);
                    end
                end else begin
                    check("idle_s", o_s, 0);
                    check("idle_done", o_seq_done, 0);
                end
                if (o_seq_done) done_pulses++;
                prev_valid = (o_s_valid != 7'd0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int d0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", o_char_ready, 1);
        check("reset_valid", o_s_valid, 0);
        check("reset_s", o_s, 0);
        check("reset_done", o_seq_done, 0);

        // Exactly 64 characters with last: count 64, not 7'h7F.
        i_request_s = 1'b1;
        d0 = done_pulses;
        push_exp(PAT_E4, 7'd64);
        send_seq(64, 1'b1);
        wait_drain();
        check("t64_done_pulses", done_pulses - d0, 1);

        // 130 characters: two full words, then a 2-character tail.
        push_exp(PAT_E4, 7'h7F);
        push_exp(PAT_E4, 7'h7F);
        push_exp(128'h4, 7'd2);
        send_seq(130, 1'b1);
        wait_drain();

        // Backpressure: request low fills both entries after 128 characters.
        i_request_s = 1'b0;
        n_acc = 0;
        push_exp(PAT_E4, 7'h7F);
        push_exp(PAT_E4, 7'h7F);
        push_exp(PAT_E4, 7'h7F);
        push_exp(128'hE4E4, 7'd8);
        fork
            send_seq(200, 1'b1);
            begin
                int t = 0;
                while (o_char_ready && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                check("full_after_128", n_acc, 128);
                repeat (3) @(negedge clk);
                check("ready_held_low", o_char_ready, 0);
                i_request_s = 1'b1;
                @(negedge clk);
                check("deliver_after_req", o_s_valid, 7'h7F);
                check("ready_after_pop", o_char_ready, 1);
            end
        join
        wait_drain();

        // Back-to-back sequences of 1 and 3 characters.
        d0 = done_pulses;
        push_exp(128'h2, 7'd1);
        push_exp(128'h31, 7'd3);
        send_char(2'd2, 1'b1);
        send_char(2'd1, 1'b0);
        send_char(2'd0, 1'b0);
        send_char(2'd3, 1'b1);
        wait_drain();
        check("b2b_done_pulses", done_pulses - d0, 2);

        // Flush mid-word; the character presented during flush is dropped.
        i_request_s = 1'b0;
        for (int k = 0; k < 10; k++) send_char(2'd1, 1'b0);
        i_flush      = 1'b1;
        i_char       = 2'd2;
        i_char_valid = 1'b1;
        @(negedge clk);
        i_flush      = 1'b0;
        i_char_valid = 1'b0;
        d0 = deliveries;
        push_exp(128'h3FF, 7'd5);
        i_request_s = 1'b1;
        for (int k = 0; k < 5; k++) send_char(2'd3, k == 4);
        wait_drain();
        check("flush_one_delivery", deliveries - d0, 1);

        // Asynchronous reset with both entries full.
        i_request_s = 1'b0;
        send_seq(128, 1'b0);
        check("pre_reset_full", o_char_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", o_char_ready, 1);
        check("async_valid", o_s_valid, 0);
        check("async_s", o_s, 0);
        check("async_done", o_seq_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        i_request_s = 1'b1;
        d0 = deliveries;
        repeat (10) @(negedge clk);
        check("no_stale_words", deliveries - d0, 0);
        push_exp(128'h3, 7'd1);
        send_char(2'd3, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
